exu_pc_seq: RTL and testbench

Multi-cycle sequencer for the PC next-state datapath of the npc core. Owns the PC register, requests instruction fetches, waits for optional load/store completion, and commits the next PC computed by the EXU PC adder only on writeback. It turns the single-cycle PC path into a handshaked fetch/execute/memory/writeback loop and detects ebreak, illegal instructions and bus timeouts.

---
 rtl/exu_pc_seq.sv | 160 ++++++++++++++++
 tb/tb_exu_pc_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_pc_seq.sv
// exu_pc_seq: multi-cycle sequencer for the npc PC next-state datapath.
//
// Owns the PC register and walks each instruction through
// fetch -> execute -> (memory) -> writeback with valid/ready handshakes.
// The EXU-computed next PC is committed only in writeback. The sequencer
// stops in HALT on ebreak and in ERR on an illegal instruction or when a
// bus response does not arrive in time.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pc_in, pc_w_en_exu            next PC and legality flag from the EXU
//   pc_out                        current PC
//   ifu_req_valid/ready           fetch request handshake at pc_out
//   ifu_resp_valid, ifu_inst      fetch response
//   inst_reg                      latched instruction for the decoder
//   is_load/is_store/is_ebreak    decoder outputs for inst_reg
//   rf_w_req                      decoder register-write request
//   lsu_req_valid/ready           memory request handshake
//   lsu_resp_valid                memory access complete
//   rf_w_en                       register file write strobe (WB only)
//   halt, err                     terminal status flags
//   instret                       retired instruction counter

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module exu_pc_seq #(
  parameter logic [`ISA_WIDTH-1:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`ISA_WIDTH-1:0] pc_in,
  input  logic                  pc_w_en_exu,
  output logic [`ISA_WIDTH-1:0] pc_out,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  input  logic                  ifu_resp_valid,
  input  logic [31:0]           ifu_inst,
  output logic [31:0]           inst_reg,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_ebreak,
  input  logic                  rf_w_req,
  output logic                  lsu_req_valid,
  input  logic                  lsu_req_ready,
  input  logic                  lsu_resp_valid,
  output logic                  rf_w_en,
  output logic                  halt,
  output logic                  err,
  output logic [31:0]           instret
);

  typedef enum logic [3:0] {
    StIdle,
    StFetchReq,
    StFetchWait,
    StExec,
    StMemReq,
    StMemWait,
    StWb,
    StHalt,
    StErr
  } state_e;

  // Last counter value tolerated without a response before giving up.
  localparam logic [8:0] WaitLast = 9'(TIMEOUT_CYCLES - 1);

  state_e                  r_state;
  logic [`ISA_WIDTH-1:0]   r_pc;
  logic [31:0]             r_inst;
  logic [31:0]             r_instret;
  logic [8:0]              r_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_instret <= '0;
      r_wait    <= '0;
    end else begin
      unique case (r_state)
        StIdle: r_state <= StFetchReq;

        StFetchReq: begin
          if (ifu_req_ready) begin
            r_state <= StFetchWait;
            r_wait  <= '0;
          end
        end

        // A response in the final allowed cycle still takes priority.
        StFetchWait: begin
          if (ifu_resp_valid) begin
            r_inst  <= ifu_inst;
            r_state <= StExec;
          end else if (r_wait == WaitLast) begin
            r_state <= StErr;
          end else begin
            r_wait <= r_wait + 9'd1;
          end
        end

        StExec: begin
          if (is_ebreak) begin
            r_instret <= r_instret + 32'd1;
            r_state   <= StHalt;
          end else if (!pc_w_en_exu) begin
            r_state <= StErr;
          end else if (is_load || is_store) begin
            r_state <= StMemReq;
          end else begin
            r_state <= StWb;
          end
        end

        StMemReq: begin
          if (lsu_req_ready) begin
            r_state <= StMemWait;
            r_wait  <= '0;
          end
        end

        StMemWait: begin
          if (lsu_resp_valid) begin
            r_state <= StWb;
          end else if (r_wait == WaitLast) begin
            r_state <= StErr;
          end else begin
            r_wait <= r_wait + 9'd1;
          end
        end

        StWb: begin
          r_pc      <= pc_in;
          r_instret <= r_instret + 32'd1;
          r_state   <= StFetchReq;
        end

        StHalt: r_state <= StHalt;
        StErr:  r_state <= StErr;

        default: r_state <= StErr;
      endcase
    end
  end

  // Moore decode; rf_w_en additionally qualifies on the decoder in WB.
  assign ifu_req_valid = (r_state == StFetchReq);
  assign lsu_req_valid = (r_state == StMemReq);
  assign rf_w_en       = (r_state == StWb) && rf_w_req && !is_store;
  assign halt          = (r_state == StHalt);
  assign err           = (r_state == StErr);
  assign pc_out        = r_pc;
  assign inst_reg      = r_inst;
  assign instret       = r_instret;

endmodule

// File: tb/tb_exu_pc_seq.sv
// Directed self-checking bench for exu_pc_seq.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_exu_pc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_w_en_exu;
  logic [31:0] pc_out;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_inst;
  logic [31:0] inst_reg;
  logic        is_load;
  logic        is_store;
  logic        is_ebreak;
  logic        rf_w_req;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic        rf_w_en;
  logic        halt;
  logic        err;
  logic [31:0] instret;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam logic [31:0] InstAddi = 32'h0010_0093;
  localparam logic [31:0] InstLw   = 32'h0000_2083;
  localparam logic [31:0] InstSw   = 32'h0010_2023;
  localparam logic [31:0] InstEbrk = 32'h0010_0073;

  exu_pc_seq dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_w_en_exu    (pc_w_en_exu),
    .pc_out         (pc_out),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_inst       (ifu_inst),
    .inst_reg       (inst_reg),
    .is_load        (is_load),
    .is_store       (is_store),
    .is_ebreak      (is_ebreak),
    .rf_w_req       (rf_w_req),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .rf_w_en        (rf_w_en),
    .halt           (halt),
    .err            (err),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic ld, input logic st, input logic eb, input logic rfw,
                         input logic wen, input logic [31:0] npc);
    is_load     = ld;
    is_store    = st;
    is_ebreak   = eb;
    rf_w_req    = rfw;
    pc_w_en_exu = wen;
    pc_in       = npc;
  endtask

  // Applies reset, checks the asynchronous reset values, and releases it.
  // Returns in the IDLE cycle.
  task automatic do_reset();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_inst       = '0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    rst = 1'b1;
    #1;
    check_eq("rst_pc", pc_out, ResetPc);
    check_eq("rst_instret", instret, 32'h0);
    check_eq("rst_ctrl", {27'h0, ifu_req_valid, lsu_req_valid, rf_w_en, halt, err}, 32'h0);
    step();
    rst = 1'b0;
  endtask

  // Called in a FETCH_REQ cycle; returns in the EXEC cycle.
  task automatic fetch(input logic [31:0] inst);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready  = 1'b0;
    ifu_inst       = inst;
    ifu_resp_valid = 1'b1;
    step();
    ifu_resp_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;

    // addi: 4-cycle path, rf_w_en in cycle 4 after IDLE, new PC in cycle 5.
    do_reset();
    check_eq("addi_c0_idle", {31'h0, ifu_req_valid}, 32'h0);
    step();
    check_eq("addi_c1_req", {31'h0, ifu_req_valid}, 32'h1);
    fetch(InstAddi);
    set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0004);
    check_eq("addi_inst_reg", inst_reg, InstAddi);
    check_eq("addi_c3_no_wen", {31'h0, rf_w_en}, 32'h0);
    step();
    check_eq("addi_c4_wen", {31'h0, rf_w_en}, 32'h1);
    check_eq("addi_c4_pc_old", pc_out, ResetPc);
    step();
    check_eq("addi_c5_pc", pc_out, 32'h8000_0004);
    check_eq("addi_c5_instret", instret, 32'h1);
    check_eq("addi_c5_req", {30'h0, ifu_req_valid, rf_w_en}, 32'h2);

    // lw: ready after 2 cycles, response 3 cycles after acceptance.
    do_reset();
    step();
    fetch(InstLw);
    set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0004);
    cnt = 0;
    step();
    if (lsu_req_valid) cnt++;
    step();
    if (lsu_req_valid) cnt++;
    step();
    if (lsu_req_valid) cnt++;
    lsu_req_ready  = 1'b1;
    lsu_resp_valid = 1'b1;  // same-cycle response must be ignored
    step();
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    if (lsu_req_valid) cnt++;
    check_eq("lw_req_cycles", cnt, 32'd3);
    step();
    check_eq("lw_wait2_no_wen", {31'h0, rf_w_en}, 32'h0);
    step();
    lsu_resp_valid = 1'b1;
    check_eq("lw_wait3_no_wen", {31'h0, rf_w_en}, 32'h0);
    step();
    lsu_resp_valid = 1'b0;
    check_eq("lw_wb_wen", {31'h0, rf_w_en}, 32'h1);
    step();
    check_eq("lw_pc", pc_out, 32'h8000_0004);
    check_eq("lw_instret", instret, 32'h1);
    step();
    step();
    check_eq("lw_single_wb", instret, 32'h1);

    // sw with rf_w_req=1: no register write, PC advances.
    do_reset();
    step();
    fetch(InstSw);
    set_dec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0004);
    lsu_req_ready = 1'b1;
    step();
    step();
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b1;
    step();
    lsu_resp_valid = 1'b0;
    check_eq("sw_wb_no_wen", {31'h0, rf_w_en}, 32'h0);
    step();
    check_eq("sw_pc", pc_out, 32'h8000_0004);
    check_eq("sw_instret", instret, 32'h1);

    // ebreak: halt, PC kept, instret bumped, no more fetches.
    do_reset();
    step();
    fetch(InstEbrk);
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    check_eq("ebrk_exec_no_halt", {31'h0, halt}, 32'h0);
    step();
    check_eq("ebrk_halt", {31'h0, halt}, 32'h1);
    check_eq("ebrk_pc", pc_out, ResetPc);
    check_eq("ebrk_instret", instret, 32'h1);
    ifu_req_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ifu_req_valid || !halt) cnt++;
    end
    ifu_req_ready = 1'b0;
    check_eq("ebrk_quiet20", cnt, 32'd0);

    // Fetch timeout: err after exactly 256 cycles in FETCH_WAIT.
    do_reset();
    step();
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < 255; i++) step();
    check_eq("to_c256_no_err", {31'h0, err}, 32'h0);
    step();
    check_eq("to_err", {31'h0, err}, 32'h1);
    check_eq("to_no_req", {31'h0, ifu_req_valid}, 32'h0);

    // Response in the 256th cycle wins over the timeout.
    do_reset();
    step();
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < 255; i++) step();
    ifu_inst       = InstAddi;
    ifu_resp_valid = 1'b1;
    step();
    ifu_resp_valid = 1'b0;
    check_eq("to_late_no_err", {31'h0, err}, 32'h0);
    check_eq("to_late_inst", inst_reg, InstAddi);

    // Illegal instruction: err, PC unchanged.
    do_reset();
    step();
    fetch(InstAddi);
    set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_dead);
    step();
    step();
    check_eq("ill_err", {31'h0, err}, 32'h1);
    check_eq("ill_pc", pc_out, ResetPc);
    check_eq("ill_instret", instret, 32'h0);

    // Reset during MEM_WAIT, then a stale memory response.
    do_reset();
    step();
    fetch(InstAddi);
    set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0004);
    step();
    step();
    check_eq("mr_pre_instret", instret, 32'h1);
    fetch(InstLw);
    set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0008);
    lsu_req_ready = 1'b1;
    step();
    step();
    lsu_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mr_rst_pc", pc_out, ResetPc);
    check_eq("mr_rst_instret", instret, 32'h0);
    step();
    rst = 1'b0;
    lsu_resp_valid = 1'b1;
    step();
    step();
    step();
    lsu_resp_valid = 1'b0;
    check_eq("mr_stale_fetch", {30'h0, ifu_req_valid, rf_w_en}, 32'h2);
    check_eq("mr_stale_pc", pc_out, ResetPc);
    check_eq("mr_stale_instret", instret, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
